key_matrix_scan: RTL and testbench

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

---
 rtl/key_matrix_scan_pkg.sv | 25 ++
 rtl/key_event_fifo.sv | 77 +++++++
 rtl/key_matrix_scan.sv | 164 ++++++++++++++++
 tb/tb_key_matrix_scan.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_matrix_scan_pkg.sv
// Shared constants, types and helpers for the 5x5 key matrix scanner.
package key_matrix_scan_pkg;

    localparam int KEY_W = 5;            // key index width
    localparam int KEY_N = 25;           // number of keys
    localparam int DIM   = 5;            // matrix dimension (rows = columns)
    localparam int EV_W  = KEY_W + 1;    // event record width

    typedef enum logic {
        ST_DRIVE  = 1'b0,
        ST_UPDATE = 1'b1
    } scan_state_e;

    // Event record, press flag above the key code.
    typedef struct packed {
        logic             press;
        logic [KEY_W-1:0] code;
    } key_event_t;

    // Active-low one-hot column drive pattern for a column index.
    function automatic logic [DIM-1:0] col_drive(input logic [2:0] col);
        col_drive = ~({{(DIM-1){1'b0}}, 1'b1} << col);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Four-entry first-word-fall-through event FIFO with sticky overflow flag.
module key_event_fifo
    import key_matrix_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  key_event_t push_data_i,
    input  logic       pop_i,
    input  logic       ovf_clr_i,
    output logic       valid_o,
    output key_event_t head_o,
    output logic       ovf_o
);

    key_event_t [3:0] mem_q;
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [2:0]       count_q;
    logic             ovf_q;

    logic full_s;
    logic empty_s;
    logic pop_s;
    logic wr_s;
    logic drop_s;

    // Pop only when data exists; a push into a full FIFO succeeds only if a pop frees a slot.
    always_comb begin
        full_s  = (count_q == 3'd4);
        empty_s = (count_q == 3'd0);
        pop_s   = pop_i && !empty_s;
        wr_s    = push_i && (!full_s || pop_s);
        drop_s  = push_i && full_s && !pop_s;
    end

    // Storage, pointers, occupancy and sticky overflow (clear has priority over set).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({wr_s, pop_s})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end else if (drop_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Head of queue is presented as soon as it exists; zero when empty.
    always_comb begin
        valid_o = !empty_s;
        ovf_o   = ovf_q;
        if (empty_s) begin
            head_o = '0;
        end else begin
            head_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 5x5 key matrix scanner: column drive, row sampling, per-key debounce, event queue.
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEB_N    = 4
) (
    input  logic             clk,
    input  logic             RSTN,
    output logic [DIM-1:0]   btn_x,
    input  logic [DIM-1:0]   btn_y,
    output logic [KEY_N-1:0] btn_state,
    output logic [KEY_N-1:0] btn_pulse,
    output logic             ev_valid,
    output logic [KEY_W-1:0] ev_code,
    output logic             ev_press,
    input  logic             ev_ready,
    output logic             ev_ovf,
    input  logic             ovf_clr
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_N + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_N - 1);

    logic                       run_q;
    logic [DIM-1:0]             sync1_q;
    logic [DIM-1:0]             sync2_q;
    scan_state_e                state_q;
    logic [DW-1:0]              dwell_q;
    logic [DIM-1:0]             raw_row_q;
    logic [2:0]                 row_q;
    logic [2:0]                 col_q;
    logic [DIM-1:0]             btn_x_q;
    logic [KEY_N-1:0]           btn_state_q;
    logic [KEY_N-1:0]           btn_pulse_q;
    logic [KEY_N-1:0][CW-1:0]   cnt_q;

    logic [KEY_W-1:0] key_idx_s;
    logic             raw_bit_s;
    logic             deb_bit_s;
    logic [CW-1:0]    cnt_cur_s;
    logic [CW-1:0]    cnt_d;
    logic             toggle_s;
    logic [2:0]       col_d;
    key_event_t       push_ev_s;
    key_event_t       head_s;

    // Release of reset is retimed so scanning starts cleanly on a clock edge.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            sync1_q <= 5'b11111;
            sync2_q <= 5'b11111;
        end else begin
            sync1_q <= btn_y;
            sync2_q <= sync1_q;
        end
    end

    // Debounce decision for the key addressed by the current column and row.
    always_comb begin
        key_idx_s = ({2'b00, col_q} * 5'd5) + {2'b00, row_q};
        raw_bit_s = raw_row_q[row_q];
        deb_bit_s = btn_state_q[key_idx_s];
        cnt_cur_s = cnt_q[key_idx_s];
        cnt_d     = cnt_cur_s;
        toggle_s  = 1'b0;
        if (run_q && (state_q == ST_UPDATE)) begin
            if (raw_bit_s == deb_bit_s) begin
                cnt_d = '0;
            end else if (cnt_cur_s == DEB_LAST) begin
                cnt_d    = '0;
                toggle_s = 1'b1;
            end else begin
                cnt_d = cnt_cur_s + CW'(1);
            end
        end else begin
            cnt_d = cnt_cur_s;
        end
        col_d           = (col_q == 3'd4) ? 3'd0 : (col_q + 3'd1);
        push_ev_s.press = ~deb_bit_s;
        push_ev_s.code  = key_idx_s;
    end

    // Scan FSM: dwell on a column, latch rows, then update one key per cycle.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_DRIVE;
            dwell_q     <= '0;
            raw_row_q   <= '0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            btn_x_q     <= 5'b11110;
            btn_state_q <= '0;
            btn_pulse_q <= '0;
            cnt_q       <= '0;
        end else begin
            btn_pulse_q <= '0;
            if (run_q) begin
                case (state_q)
                    ST_DRIVE: begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_q   <= '0;
                            raw_row_q <= ~sync2_q;
                            row_q     <= 3'd0;
                            state_q   <= ST_UPDATE;
                        end else begin
                            dwell_q <= dwell_q + DW'(1);
                        end
                    end
                    ST_UPDATE: begin
                        cnt_q[key_idx_s] <= cnt_d;
                        if (toggle_s) begin
                            btn_state_q[key_idx_s] <= ~deb_bit_s;
                            btn_pulse_q[key_idx_s] <= ~deb_bit_s;
                        end
                        if (row_q == 3'd4) begin
                            row_q   <= 3'd0;
                            col_q   <= col_d;
                            btn_x_q <= col_drive(col_d);
                            state_q <= ST_DRIVE;
                        end else begin
                            row_q <= row_q + 3'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_DRIVE;
                        dwell_q <= '0;
                        row_q   <= 3'd0;
                    end
                endcase
            end
        end
    end

    key_event_fifo u_fifo (
        .clk         (clk),
        .rst_n       (RSTN),
        .push_i      (toggle_s),
        .push_data_i (push_ev_s),
        .pop_i       (ev_ready),
        .ovf_clr_i   (ovf_clr),
        .valid_o     (ev_valid),
        .head_o      (head_s),
        .ovf_o       (ev_ovf)
    );

    assign btn_x     = btn_x_q;
    assign btn_state = btn_state_q;
    assign btn_pulse = btn_pulse_q;
    assign ev_code   = head_s.code;
    assign ev_press  = head_s.press;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with SCAN_DIV=8, DEB_N=4 (65-cycle frame).
module tb_key_matrix_scan;

    logic        clk;
    logic        RSTN;
    logic [4:0]  btn_x;
    logic [4:0]  btn_y;
    logic [24:0] btn_state;
    logic [24:0] btn_pulse;
    logic        ev_valid;
    logic [4:0]  ev_code;
    logic        ev_press;
    logic        ev_ready;
    logic        ev_ovf;
    logic        ovf_clr;
    logic [24:0] keys;

    int vec;
    int miss;

    // frame monitor state
    int          frame_no;
    int          ch_cnt;
    int          ch_frame;
    int          pulse_cyc;
    int          pulse_bad;
    int          valid_seen;
    logic [4:0]  prev_x;
    logic [4:0]  ch_x;
    logic [24:0] ch_pulse;
    logic        prev_state;

    key_matrix_scan #(.SCAN_DIV(8), .DEB_N(4)) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .btn_x     (btn_x),
        .btn_y     (btn_y),
        .btn_state (btn_state),
        .btn_pulse (btn_pulse),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_press  (ev_press),
        .ev_ready  (ev_ready),
        .ev_ovf    (ev_ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        btn_y = 5'b11111;
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 5; r++) begin
                if (!btn_x[c] && keys[c*5+r]) btn_y[r] = 1'b0;
            end
        end
    end

    task automatic clear_mon(input int watch);
        ch_cnt = 0; ch_frame = 0; ch_x = 5'd0; ch_pulse = 25'd0;
        pulse_cyc = 0; pulse_bad = 0; valid_seen = 0;
        prev_state = btn_state[watch];
    endtask

    task automatic reset_dut(input logic [24:0] k);
        @(negedge clk);
        RSTN = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0; keys = k;
        repeat (3) @(negedge clk);
        RSTN = 1'b1;
        frame_no = 1;
        prev_x = 5'b11110;
    endtask

    // Advance until frame `target` begins, recording activity of key `watch`.
    task automatic run_until_frame(input int target, input int watch);
        int guard;
        logic [24:0] mask;
        guard = 0;
        mask = 25'd1 << watch;
        while (frame_no < target) begin
            if (guard >= 1000) begin
                vec++; miss++;
                $display("FAIL frame_timeout: reached frame %0d expected frame %0d", frame_no, target);
                break;
            end
            @(negedge clk);
            guard++;
            if (prev_x == 5'b01111 && btn_x == 5'b11110) frame_no++;
            prev_x = btn_x;
            if (btn_state[watch] != prev_state) begin
                ch_cnt++; ch_frame = frame_no; ch_x = btn_x; ch_pulse = btn_pulse;
            end
            prev_state = btn_state[watch];
            if (btn_pulse[watch]) pulse_cyc++;
            if ((btn_pulse & ~mask) != 25'd0) pulse_bad++;
            if (ev_valid) valid_seen++;
        end
    endtask

    task automatic wait_key3;
        int guard;
        guard = 0;
        while (!btn_state[3] && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        vec++;
        if (!btn_state[3]) begin
            miss++;
            $display("FAIL wait_key3: btn_state[3] got 0 expected 1 within 400 cycles");
        end
    endtask

    task automatic pop_one;
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic test_reset;
        RSTN = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0; keys = 25'd0;
        #2 RSTN = 1'b0;
        #1;
        vec++; if (btn_x !== 5'b11110) begin miss++; $display("FAIL rst_btn_x: got %b expected 11110", btn_x); end
        vec++; if (btn_state !== 25'd0) begin miss++; $display("FAIL rst_state: got %h expected 0", btn_state); end
        vec++; if (btn_pulse !== 25'd0) begin miss++; $display("FAIL rst_pulse: got %h expected 0", btn_pulse); end
        vec++; if (ev_valid !== 1'b0) begin miss++; $display("FAIL rst_valid: got %b expected 0", ev_valid); end
        vec++; if (ev_code !== 5'd0) begin miss++; $display("FAIL rst_code: got %0d expected 0", ev_code); end
        vec++; if (ev_press !== 1'b0) begin miss++; $display("FAIL rst_press: got %b expected 0", ev_press); end
        vec++; if (ev_ovf !== 1'b0) begin miss++; $display("FAIL rst_ovf: got %b expected 0", ev_ovf); end
    endtask

    task automatic test_scan;
        int col;
        logic [4:0] exp_x;
        @(negedge clk);
        RSTN = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            col = (k < 14) ? 0 : (((k - 14) / 13 + 1) % 5);
            exp_x = ~(5'b00001 << col);
            vec++; if (btn_x !== exp_x) begin miss++; $display("FAIL scan_btn_x cycle %0d: got %b expected %b", k, btn_x, exp_x); end
            vec++; if (ev_valid !== 1'b0) begin miss++; $display("FAIL scan_valid cycle %0d: got %b expected 0", k, ev_valid); end
        end
    endtask

    task automatic test_press_release;
        logic [24:0] exp_p;
        exp_p = 25'd1 << 13;
        reset_dut(exp_p);
        clear_mon(13);
        run_until_frame(7, 13);
        vec++; if (ch_cnt != 1) begin miss++; $display("FAIL press_changes: got %0d expected 1", ch_cnt); end
        vec++; if (ch_frame != 4) begin miss++; $display("FAIL press_frame: got %0d expected 4", ch_frame); end
        vec++; if (ch_x !== 5'b11011) begin miss++; $display("FAIL press_column: got %b expected 11011", ch_x); end
        vec++; if (ch_pulse !== exp_p) begin miss++; $display("FAIL press_pulse_bits: got %h expected %h", ch_pulse, exp_p); end
        vec++; if (pulse_cyc != 1) begin miss++; $display("FAIL press_pulse_len: got %0d expected 1", pulse_cyc); end
        vec++; if (pulse_bad != 0) begin miss++; $display("FAIL press_pulse_other: got %0d expected 0", pulse_bad); end
        vec++; if (ev_valid !== 1'b1 || ev_code !== 5'd13 || ev_press !== 1'b1) begin
            miss++; $display("FAIL press_event: got v%b c%0d p%b expected v1 c13 p1", ev_valid, ev_code, ev_press); end
        keys = 25'd0;
        clear_mon(13);
        run_until_frame(11, 13);
        vec++; if (ch_cnt != 1) begin miss++; $display("FAIL release_changes: got %0d expected 1", ch_cnt); end
        vec++; if (ch_frame != 10) begin miss++; $display("FAIL release_frame: got %0d expected 10", ch_frame); end
        vec++; if (ch_x !== 5'b11011) begin miss++; $display("FAIL release_column: got %b expected 11011", ch_x); end
        vec++; if (pulse_cyc != 0) begin miss++; $display("FAIL release_pulse: got %0d expected 0", pulse_cyc); end
        pop_one();
        vec++; if (ev_valid !== 1'b1 || ev_code !== 5'd13 || ev_press !== 1'b0) begin
            miss++; $display("FAIL release_event: got v%b c%0d p%b expected v1 c13 p0", ev_valid, ev_code, ev_press); end
        pop_one();
        vec++; if (ev_valid !== 1'b0) begin miss++; $display("FAIL release_empty: got %b expected 0", ev_valid); end
    endtask

    task automatic test_bounce;
        reset_dut(25'd0);
        clear_mon(5);
        for (int f = 1; f <= 8; f++) begin
            keys[5] = f[0];
            run_until_frame(f + 1, 5);
        end
        vec++; if (ch_cnt != 0) begin miss++; $display("FAIL bounce_changes: got %0d expected 0", ch_cnt); end
        vec++; if (pulse_cyc != 0) begin miss++; $display("FAIL bounce_pulse: got %0d expected 0", pulse_cyc); end
        vec++; if (valid_seen != 0) begin miss++; $display("FAIL bounce_events: got %0d expected 0", valid_seen); end
    endtask

    task automatic test_overflow;
        reset_dut(25'h000001F);
        clear_mon(0);
        run_until_frame(6, 0);
        vec++; if (ev_ovf !== 1'b1) begin miss++; $display("FAIL ovf_set: got %b expected 1", ev_ovf); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        vec++; if (ev_ovf !== 1'b0) begin miss++; $display("FAIL ovf_clear: got %b expected 0", ev_ovf); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (ev_valid !== 1'b1 || ev_code !== 5'(i) || ev_press !== 1'b1) begin
                miss++; $display("FAIL ovf_order %0d: got v%b c%0d p%b expected v1 c%0d p1", i, ev_valid, ev_code, ev_press, i); end
            pop_one();
        end
        vec++; if (ev_valid !== 1'b0) begin miss++; $display("FAIL ovf_empty: got %b expected 0", ev_valid); end
    endtask

    task automatic test_back_to_back;
        reset_dut(25'h000001F);
        wait_key3();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        vec++; if (ev_ovf !== 1'b0) begin miss++; $display("FAIL full_pop_ovf: got %b expected 0", ev_ovf); end
        vec++; if (btn_state[4] !== 1'b1) begin miss++; $display("FAIL full_pop_key4: got %b expected 1", btn_state[4]); end
        for (int i = 1; i <= 4; i++) begin
            vec++; if (ev_valid !== 1'b1 || ev_code !== 5'(i)) begin
                miss++; $display("FAIL full_pop_order %0d: got v%b c%0d expected v1 c%0d", i, ev_valid, ev_code, i); end
            pop_one();
        end
        vec++; if (ev_valid !== 1'b0) begin miss++; $display("FAIL full_pop_empty: got %b expected 0", ev_valid); end
    endtask

    task automatic test_clr_priority;
        reset_dut(25'h000001F);
        wait_key3();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        vec++; if (btn_state[4] !== 1'b1) begin miss++; $display("FAIL clr_prio_key4: got %b expected 1", btn_state[4]); end
        vec++; if (ev_ovf !== 1'b0) begin miss++; $display("FAIL clr_prio_ovf: got %b expected 0", ev_ovf); end
        @(negedge clk);
        vec++; if (ev_ovf !== 1'b0) begin miss++; $display("FAIL clr_prio_hold: got %b expected 0", ev_ovf); end
        vec++; if (ev_code !== 5'd0) begin miss++; $display("FAIL clr_prio_head: got %0d expected 0", ev_code); end
    endtask

    task automatic test_reset_mid_update;
        int guard;
        reset_dut(25'd1 << 13);
        clear_mon(13);
        run_until_frame(5, 13);
        vec++; if (btn_state[13] !== 1'b1) begin miss++; $display("FAIL mid_pre_state: got %b expected 1", btn_state[13]); end
        guard = 0;
        while (btn_x !== 5'b10111 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        vec++; if (btn_x !== 5'b10111) begin miss++; $display("FAIL mid_col3: got %b expected 10111", btn_x); end
        repeat (10) @(negedge clk);
        RSTN = 1'b0;
        #1;
        vec++; if (btn_x !== 5'b11110) begin miss++; $display("FAIL mid_btn_x: got %b expected 11110", btn_x); end
        vec++; if (btn_state !== 25'd0) begin miss++; $display("FAIL mid_state: got %h expected 0", btn_state); end
        vec++; if (btn_pulse !== 25'd0) begin miss++; $display("FAIL mid_pulse: got %h expected 0", btn_pulse); end
        vec++; if (ev_valid !== 1'b0) begin miss++; $display("FAIL mid_valid: got %b expected 0", ev_valid); end
        vec++; if (ev_code !== 5'd0 || ev_press !== 1'b0) begin miss++; $display("FAIL mid_head: got c%0d p%b expected c0 p0", ev_code, ev_press); end
        vec++; if (ev_ovf !== 1'b0) begin miss++; $display("FAIL mid_ovf: got %b expected 0", ev_ovf); end
        repeat (2) @(negedge clk);
        RSTN = 1'b1;
        frame_no = 1;
        prev_x = 5'b11110;
        clear_mon(13);
        run_until_frame(5, 13);
        vec++; if (ch_cnt != 1) begin miss++; $display("FAIL mid_redetect: got %0d expected 1", ch_cnt); end
        vec++; if (ch_frame != 4) begin miss++; $display("FAIL mid_frame: got %0d expected 4", ch_frame); end
        vec++; if (ch_x !== 5'b11011) begin miss++; $display("FAIL mid_column: got %b expected 11011", ch_x); end
    endtask

    initial begin
        vec = 0;
        miss = 0;
        frame_no = 1;
        prev_x = 5'b11110;
        test_reset();
        test_scan();
        test_press_release();
        test_bounce();
        test_overflow();
        test_back_to_back();
        test_clr_priority();
        test_reset_mid_update();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
